// File: rtl/tap_merge4.sv
// Four-lane tap merger: re-serialises one 15-bit tap per lane onto a single
// stream in strict lane order 0..3, flagging lane 3 as end of group.
// Optional running group sum on out_sum when TAP_MERGE_SUM_EN is defined.
module tap_merge4 #(
  parameter int DATA_W = 15,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_0,
  input  logic              in_valid_1,
  input  logic              in_valid_2,
  input  logic              in_valid_3,
  input  logic [DATA_W-1:0] in_data_0,
  input  logic [DATA_W-1:0] in_data_1,
  input  logic [DATA_W-1:0] in_data_2,
  input  logic [DATA_W-1:0] in_data_3,
  output logic              in_ready_0,
  output logic              in_ready_1,
  output logic              in_ready_2,
  output logic              in_ready_3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_lane,
  output logic              out_last,
  output logic [CNT_W-1:0]  grp_cnt
`ifdef TAP_MERGE_SUM_EN
  ,
  output logic [DATA_W+1:0] out_sum
`endif
);

  logic [3:0]        in_valid;
  logic [3:0]        full;
  logic [DATA_W-1:0] in_data  [4];
  logic [DATA_W-1:0] lane_buf [4];
  logic [1:0]        sel;
  logic              load;

  assign in_valid   = {in_valid_3, in_valid_2, in_valid_1, in_valid_0};
  assign in_data[0] = in_data_0;
  assign in_data[1] = in_data_1;
  assign in_data[2] = in_data_2;
  assign in_data[3] = in_data_3;

  // in_ready comes straight from the full flags, so it never depends on out_ready
  assign in_ready_0 = ~full[0];
  assign in_ready_1 = ~full[1];
  assign in_ready_2 = ~full[2];
  assign in_ready_3 = ~full[3];

  assign load = full[sel] && (!out_valid || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
      for (int i = 0; i < 4; i++) lane_buf[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (load && (sel == 2'(i))) begin
          full[i] <= 1'b0;
        end else if (in_valid[i] && !full[i]) begin
          full[i]     <= 1'b1;
          lane_buf[i] <= in_data[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_lane  <= 2'd0;
      out_last  <= 1'b0;
      sel       <= 2'd0;
      grp_cnt   <= '0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= lane_buf[sel];
        out_lane  <= sel;
        out_last  <= (sel == 2'd3);
        sel       <= sel + 2'd1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid && out_ready && out_last) begin
        grp_cnt <= grp_cnt + CNT_W'(1);
      end
    end
  end

`ifdef TAP_MERGE_SUM_EN
  // Two guard bits make the sum of four full-scale taps exact
  logic [DATA_W+1:0] acc;
  logic [DATA_W+1:0] tap_ext;

  assign tap_ext = {2'b00, lane_buf[sel]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      out_sum <= '0;
    end else if (load) begin
      if (sel == 2'd0) acc <= tap_ext;
      else             acc <= acc + tap_ext;
      if (sel == 2'd3) out_sum <= acc + tap_ext;
    end
  end
`endif

endmodule

// File: tb/tb_tap_merge4.sv
// Self-checking bench for tap_merge4: directed scenarios plus random traffic
// checked against per-lane queues that model the strict 0..3 output order.
module tb_tap_merge4;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [14:0] in_data [4];
  logic [3:0]  in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] out_data;
  logic [1:0]  out_lane;
  logic        out_last;
  logic [15:0] grp_cnt;
`ifdef TAP_MERGE_SUM_EN
  logic [16:0] out_sum;
`endif

  int checks = 0;
  int errors = 0;

  tap_merge4 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_0 (in_valid[0]),
    .in_valid_1 (in_valid[1]),
    .in_valid_2 (in_valid[2]),
    .in_valid_3 (in_valid[3]),
    .in_data_0  (in_data[0]),
    .in_data_1  (in_data[1]),
    .in_data_2  (in_data[2]),
    .in_data_3  (in_data[3]),
    .in_ready_0 (in_ready[0]),
    .in_ready_1 (in_ready[1]),
    .in_ready_2 (in_ready[2]),
    .in_ready_3 (in_ready[3]),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_lane   (out_lane),
    .out_last   (out_last),
    .grp_cnt    (grp_cnt)
`ifdef TAP_MERGE_SUM_EN
    ,
    .out_sum    (out_sum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present taps on the lanes in mask for one cycle; called and returns at posedge+1
  task automatic applyStimulus(input logic [3:0] mask, input logic [14:0] d0, input logic [14:0] d1,
                               input logic [14:0] d2, input logic [14:0] d3);
    in_data[0] = d0;
    in_data[1] = d1;
    in_data[2] = d2;
    in_data[3] = d3;
    in_valid   = mask;
    @(posedge clk);
    #1;
    in_valid = 4'b0000;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: taps accepted per lane, emitted strictly in lane order
  logic [14:0] lane_q [4][$];
  int          exp_sel;
  logic [15:0] exp_grp;
  logic [16:0] exp_sum;
  logic        prev_stall;
  logic [14:0] prev_data;
  logic [1:0]  prev_lane;
  logic        prev_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) lane_q[i].delete();
      exp_sel    = 0;
      exp_grp    = '0;
      exp_sum    = '0;
      prev_stall = 1'b0;
    end else begin
      checkOutput("grp_cnt", 32'(grp_cnt), 32'(exp_grp));
      if (prev_stall) begin
        checkOutput("hold_valid", 32'(out_valid), 32'd1);
        checkOutput("hold_data", 32'(out_data), 32'(prev_data));
        checkOutput("hold_lane", 32'(out_lane), 32'(prev_lane));
        checkOutput("hold_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) begin
        checkOutput("order_lane", 32'(out_lane), 32'(exp_sel));
        checkOutput("tap_present", 32'(lane_q[exp_sel].size() > 0), 32'd1);
        if (lane_q[exp_sel].size() > 0) begin
          logic [14:0] d;
          d = lane_q[exp_sel].pop_front();
          checkOutput("order_data", 32'(out_data), 32'(d));
          exp_sum = (exp_sel == 0) ? 17'(d) : exp_sum + 17'(d);
        end
        checkOutput("last_flag", 32'(out_last), 32'(exp_sel == 3));
`ifdef TAP_MERGE_SUM_EN
        if (exp_sel == 3) checkOutput("group_sum", 32'(out_sum), 32'(exp_sum));
`endif
        if (exp_sel == 3) exp_grp = exp_grp + 16'd1;
        exp_sel = (exp_sel + 1) % 4;
      end
      for (int i = 0; i < 4; i++) begin
        if (in_valid[i] && in_ready[i]) lane_q[i].push_back(in_data[i]);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_lane  = out_lane;
      prev_last  = out_last;
    end
  end

  initial begin
    logic [14:0] tap_set [4];
    in_valid  = 4'b0000;
    for (int i = 0; i < 4; i++) in_data[i] = '0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    waitCycles(2);
    rst_n = 1'b1;

    // Reset then idle
    checkOutput("rst_in_ready", 32'(in_ready), 32'hF);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_grp_cnt", 32'(grp_cnt), 32'd0);

    // In-order merge, all four lanes in one cycle
    tap_set = '{15'h0011, 15'h0022, 15'h0033, 15'h0044};
    applyStimulus(4'hF, tap_set[0], tap_set[1], tap_set[2], tap_set[3]);
    checkOutput("latency_pre", 32'(out_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      waitCycles(1);
      checkOutput("burst_valid", 32'(out_valid), 32'd1);
      checkOutput("burst_lane", 32'(out_lane), 32'(k));
      checkOutput("burst_data", 32'(out_data), 32'(tap_set[k]));
      checkOutput("burst_last", 32'(out_last), 32'(k == 3));
    end
    waitCycles(1);
    checkOutput("burst_idle", 32'(out_valid), 32'd0);
    checkOutput("burst_grp", 32'(grp_cnt), 32'd1);

    // Out-of-order arrival: lane 3, 1, 0, 2
    applyStimulus(4'b1000, 15'h0, 15'h0, 15'h0, 15'h7FFF);
    waitCycles(5);
    checkOutput("ooo_ready3_a", 32'(in_ready[3]), 32'd0);
    checkOutput("ooo_idle_a", 32'(out_valid), 32'd0);
    applyStimulus(4'b0010, 15'h0, 15'h0155, 15'h0, 15'h0);
    waitCycles(5);
    checkOutput("ooo_ready3_b", 32'(in_ready[3]), 32'd0);
    checkOutput("ooo_idle_b", 32'(out_valid), 32'd0);
    applyStimulus(4'b0001, 15'h0AAA, 15'h0, 15'h0, 15'h0);
    waitCycles(5);
    checkOutput("ooo_ready3_c", 32'(in_ready[3]), 32'd0);
    checkOutput("ooo_wait_lane2", 32'(out_valid), 32'd0);
    applyStimulus(4'b0100, 15'h0, 15'h0, 15'h1234, 15'h0);
    waitCycles(5);
    checkOutput("ooo_ready3_d", 32'(in_ready[3]), 32'd1);
    checkOutput("ooo_grp", 32'(grp_cnt), 32'd2);

    // Backpressure mid-group after lane 0 has gone out
    applyStimulus(4'hF, 15'h0101, 15'h0202, 15'h0303, 15'h0404);
    waitCycles(2);
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      waitCycles(1);
      checkOutput("bp_lane", 32'(out_lane), 32'd1);
      checkOutput("bp_data", 32'(out_data), 32'h0202);
    end
    out_ready = 1'b1;
    waitCycles(4);
    checkOutput("bp_grp", 32'(grp_cnt), 32'd3);
    checkOutput("bp_idle", 32'(out_valid), 32'd0);

    // Asynchronous reset after two taps of a group have been emitted
    applyStimulus(4'hF, 15'h0E01, 15'h0E02, 15'h0E03, 15'h0E04);
    waitCycles(3);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", 32'(out_valid), 32'd0);
    checkOutput("arst_grp", 32'(grp_cnt), 32'd0);
    checkOutput("arst_ready", 32'(in_ready), 32'hF);
    @(negedge clk);
    #1 rst_n = 1'b1;
    waitCycles(1);
    applyStimulus(4'hF, 15'h0F01, 15'h0F02, 15'h0F03, 15'h0F04);
    waitCycles(1);
    checkOutput("arst_restart_lane", 32'(out_lane), 32'd0);
    checkOutput("arst_restart_data", 32'(out_data), 32'h0F01);
    waitCycles(5);

`ifdef TAP_MERGE_SUM_EN
    // Full-scale taps must not overflow the widened sum
    applyStimulus(4'hF, 15'h7FFF, 15'h7FFF, 15'h7FFF, 15'h7FFF);
    waitCycles(4);
    checkOutput("sum_last", 32'(out_last), 32'd1);
    checkOutput("sum_max", 32'(out_sum), 32'h1FFFC);
    waitCycles(2);
`endif

    // Random traffic with random backpressure
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 4; i++) begin
        in_valid[i] = 1'($urandom_range(0, 1));
        in_data[i]  = 15'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      waitCycles(1);
    end
    in_valid  = 4'b0000;
    out_ready = 1'b1;
    waitCycles(20);
    checkOutput("final_grp_nonzero", 32'(grp_cnt != 16'd0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tap_merge4.md
Name: tap_merge4

Overview:
- Gathers four 15-bit interpolation taps arriving on four independent lanes.
- Re-serialises them onto one stream in strict lane order 0,1,2,3, marking the end of each group.
- Inverse of the 1-to-4 tap distributor: sits after the per-tap processing lanes and feeds the single downstream interpolation stage.
- Valid/ready handshake on every lane and on the output.

Parameters:
DATA_W, 15, width of each tap value and of out_data
CNT_W, 16, width of the completed-group counter

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid_0..in_valid_3  input  1 each  lane i data valid
in_data_0..in_data_3  input  DATA_W each  lane i tap value
in_ready_0..in_ready_3  output  1 each  lane i can accept
out_valid  output  1  out_data holds a tap
out_ready  input  1  downstream accepts
out_data  output  DATA_W  merged tap
out_lane  output  2  lane index of out_data
out_last  output  1  high with lane-3 tap (end of group)
grp_cnt  output  CNT_W  completed groups, wraps

Behaviour:
- Reset (rst_n low, asynchronous) clears all of the following; in-flight data is discarded and no partial group survives reset.
  - All lane buffers empty, so in_ready_i = 1 once rst_n is released.
  - out_valid, out_data, out_lane, out_last = 0.
  - grp_cnt = 0; sel = 0.
- Lane buffer i is a one-entry register with flag full_i.
  - in_ready_i = !full_i (registered; no combinational path from out_ready).
  - Accept on in_valid_i && in_ready_i: latch data, set full_i.
- sel is a 2-bit pointer to the next lane to emit. Order is strict: lane k is never emitted before lane k-1 of the same group, even if lane k is full earlier.
- Output register load condition: full_sel && (!out_valid || out_ready). On load:
  - out_data = buffer[sel]; out_lane = sel; out_last = (sel == 3); out_valid = 1.
  - full_sel cleared.
  - sel increments, wrapping 3 -> 0.
- Output hold:
  - out_valid && out_ready with no new load: out_valid = 0 on the next edge.
  - out_valid && !out_ready: out_data, out_lane and out_last hold stable. No load occurs and sel does not advance.
- grp_cnt increments on every output handshake with out_last = 1 and wraps from 2^CNT_W-1 to 0.
- Latency: a lane handshake at edge N, for the lane currently at sel, gives out_valid at edge N+1.
- Throughput: one tap per cycle while lanes are prefilled and out_ready = 1. Each lane sustains one tap per two cycles; only one per four is needed.
- Simultaneous events: a lane may accept on the same edge that another lane's buffer is drained. The lane being drained cannot accept that cycle, since its in_ready was 0.
- Empty buffer at sel: output goes idle (out_valid drops after the pending handshake) and sel waits on that lane indefinitely; there is no timeout.

Optional Feature:
- Macro TAP_MERGE_SUM_EN. When defined, adds output port out_sum (DATA_W+2 bits, unsigned).
  - An accumulator updates on each output load: acc = data when sel == 0, else acc + data.
  - On the lane-3 load, out_sum is registered as acc_prev + data alongside out_last and holds with the output register.
  - out_sum is reset to 0.
  - out_sum is meaningful only while out_valid && out_last.
- When not defined: no out_sum port, no accumulator logic; all other behaviour is identical.

Test Plan:
- Reset then idle: rst_n = 0, release. Expect in_ready_0..3 = 1, out_valid = 0, grp_cnt = 0.
- In-order merge: present 0x0011, 0x0022, 0x0033, 0x0044 on lanes 0..3 in one cycle, out_ready = 1. Expect four consecutive beats 0x0011..0x0044 with out_lane 0..3, out_last only on 0x0044, then grp_cnt = 1.
- Out-of-order arrival: lane 3 = 0x7FFF first, then lane 1, then lane 0, then lane 2, 5 cycles apart. Expect output order lanes 0, 1, 2, 3; in_ready_3 stays 0 until lane 3 is emitted.
- Backpressure: out_ready = 0 for 10 cycles mid-group. Expect out_data, out_lane and out_last stable and sel frozen; resuming completes the group with no loss or duplication.
- Async reset mid-group after 2 of 4 taps emitted: expect immediate clear, next group starts at lane 0, and grp_cnt = 0.
- With TAP_MERGE_SUM_EN: taps 0x7FFF x4. Expect out_sum = 0x1FFFC on the last beat, with no overflow at DATA_W+2 bits.
